// File: rtl/edge_io_pkg.sv
// edge_io_pkg: shared pixel width, sequencer state encoding and default SRAM base addresses
package edge_io_pkg;
   localparam int PIXEL_W = 8;
   localparam logic [31:0] RD_BASE_DEF = 32'h0000_0000;
   localparam logic [31:0] WR_BASE_DEF = 32'h0010_0000;
   typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, HOLD} anchor_io_state_t;
endpackage

// File: rtl/anchor_io_sequencer_if.sv
// anchor_io_sequencer_if: SRAM request/response bus between the sequencer (master) and memory (slave)
interface anchor_io_sequencer_if;
   logic [31:0] mem_addr;
   logic mem_read;
   logic mem_write;
   logic [edge_io_pkg::PIXEL_W-1:0] mem_wdata;
   logic [edge_io_pkg::PIXEL_W-1:0] mem_rdata;
   logic mem_ack;
   modport master(output mem_addr, mem_read, mem_write, mem_wdata, input mem_rdata, mem_ack);
   modport slave(input mem_addr, mem_read, mem_write, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/strip_addr_gen.sv
// strip_addr_gen: base + row*stride + col, 32-bit truncating
module strip_addr_gen (
   input  logic [31:0] base,
   input  logic [31:0] row,
   input  logic [31:0] stride,
   input  logic [31:0] col,
   output logic [31:0] addr
);
   assign addr = base + row * stride + col;
endmodule

// File: rtl/anchor_io_sequencer.sv
// anchor_io_sequencer: fetches a column strip at the anchor and writes back the lagging result strip.
// ANCHOR_IO_EDGE_REPLICATE_EN: rows below the image copy the previous pixel instead of zero-filling.
module anchor_io_sequencer
   import edge_io_pkg::*;
#(
   parameter int STRIP_H = 20,
   parameter int WR_H = 10,
   parameter int WR_ROW_OFF = 5,
   parameter int X_LAG = 5,
   parameter logic [31:0] RD_BASE = RD_BASE_DEF,
   parameter logic [31:0] WR_BASE = WR_BASE_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic read_enable,
   input  logic write_enable,
   input  logic anchor_moving,
   input  logic [31:0] anchor_x,
   input  logic [31:0] anchor_y,
   input  logic [31:0] img_width,
   input  logic [31:0] img_height,
   input  logic [PIXEL_W*WR_H-1:0] wr_data,
   anchor_io_sequencer_if.master mem,
   output logic [PIXEL_W*STRIP_H-1:0] col_data,
   output logic col_valid,
   output logic io_final
);
   localparam int SW = PIXEL_W * STRIP_H;
   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_SETUP = SETUP;
   localparam logic [2:0] S_READ = READ;
   localparam logic [2:0] S_WRITE = WRITE;
   localparam logic [2:0] S_HOLD = HOLD;
   localparam logic [SW-1:0] PIX_MASK = {{(SW-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};
   logic [2:0] state_q, state_d;
   logic [31:0] k_q, k_d, ax_q, ax_d, ay_q, ay_d;
   logic col_ok_q, col_ok_d, wr_ok_q, wr_ok_d, col_valid_q, col_valid_d;
   logic [PIXEL_W*WR_H-1:0] wbuf_q, wbuf_d;
   logic [SW-1:0] pix_q, pix_d, col_q, col_d, pix_upd;
   logic [31:0] rd_row, wr_row, wr_col, sh, addr;
   logic rd_req, wr_req, done, wr_st, last;
   logic [PIXEL_W-1:0] fill, pix_new;
   assign wr_st = state_q == S_WRITE;
   assign rd_row = ay_q + k_q;
   assign wr_row = ay_q + 32'(WR_ROW_OFF) + k_q;
   assign wr_col = ax_q - 32'(X_LAG);
   assign rd_req = state_q == S_READ && col_ok_q && rd_row < img_height;
   assign wr_req = wr_st && wr_row < img_height;
   assign done = !(rd_req || wr_req) || mem.mem_ack;
   assign last = k_q == (wr_st ? 32'(WR_H - 1) : 32'(STRIP_H - 1));
   assign sh = k_q * PIXEL_W;
   strip_addr_gen u_addr (
      .base  (wr_st ? WR_BASE : RD_BASE),
      .row   (wr_st ? wr_row : rd_row),
      .stride(img_width),
      .col   (wr_st ? wr_col : ax_q),
      .addr  (addr)
   );
   assign mem.mem_addr = (rd_req || wr_req) ? addr : '0;
   assign mem.mem_read = rd_req;
   assign mem.mem_write = wr_req;
   assign mem.mem_wdata = wr_req ? PIXEL_W'(wbuf_q >> sh) : '0;
`ifdef ANCHOR_IO_EDGE_REPLICATE_EN
   assign fill = (col_ok_q && k_q != 0) ? PIXEL_W'(pix_q >> (sh - PIXEL_W)) : '0;
`else
   assign fill = '0;
`endif
   assign pix_new = rd_req ? mem.mem_rdata : fill;
   assign pix_upd = (pix_q & ~(PIX_MASK << sh)) | (SW'(pix_new) << sh);
   assign col_data = col_q;
   assign col_valid = col_valid_q;
   assign io_final = state_q == S_HOLD;
   always_comb begin
      state_d = state_q;
      k_d = k_q;
      ax_d = ax_q;
      ay_d = ay_q;
      col_ok_d = col_ok_q;
      wr_ok_d = wr_ok_q;
      wbuf_d = wbuf_q;
      pix_d = pix_q;
      col_d = col_q;
      col_valid_d = 1'b0;
      case (state_q)
         S_IDLE: state_d = read_enable ? S_SETUP : S_IDLE;
         S_SETUP: begin
            ax_d = anchor_x;
            ay_d = anchor_y;
            wbuf_d = wr_data;
            col_ok_d = anchor_x < img_width;
            wr_ok_d = anchor_x >= 32'(X_LAG) && anchor_x - 32'(X_LAG) < img_width;
            k_d = '0;
            state_d = S_READ;
         end
         S_READ: if (done) begin
            pix_d = pix_upd;
            k_d = last ? '0 : k_q + 1;
            if (!read_enable) state_d = S_IDLE;
            else if (last) begin
               col_d = pix_upd;
               col_valid_d = 1'b1;
               state_d = (write_enable && wr_ok_q) ? S_WRITE : S_HOLD;
            end
         end
         S_WRITE: if (done) begin
            k_d = k_q + 1;
            state_d = !read_enable ? S_IDLE : last ? S_HOLD : S_WRITE;
         end
         S_HOLD: state_d = !read_enable ? S_IDLE : anchor_moving ? S_SETUP : S_HOLD;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         k_q <= '0;
         ax_q <= '0;
         ay_q <= '0;
         col_ok_q <= 1'b0;
         wr_ok_q <= 1'b0;
         wbuf_q <= '0;
         pix_q <= '0;
         col_q <= '0;
         col_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q <= k_d;
         ax_q <= ax_d;
         ay_q <= ay_d;
         col_ok_q <= col_ok_d;
         wr_ok_q <= wr_ok_d;
         wbuf_q <= wbuf_d;
         pix_q <= pix_d;
         col_q <= col_d;
         col_valid_q <= col_valid_d;
      end
   end
endmodule
